// File: rtl/sdc_pkg.sv
// Shared types and defaults for the serial demux control FSM.
// State encoding is fixed so the datapath and debug tooling can decode it.
package sdc_pkg;

   localparam int PORT_BITS_DEF = 2;
   localparam int LEN_BITS_DEF  = 4;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PORT = 3'd1,
      ST_LEN  = 3'd2,
      ST_LOAD = 3'd3,
      ST_DATA = 3'd4
   } sdc_state_e;

   typedef struct packed {
      logic sh_en;
      logic cnt1;
      logic sh_en_d;
      logic cnt2;
      logic ld_cnt_d;
      logic cnt_d;
      logic data_valid;
      logic done;
   } sdc_strobes_t;

   // Enabled slots in one frame: start, port, length, turnaround, payload, stop.
   function automatic int frame_slots(input int port_bits, input int len_bits, input int n);
      return 1 + port_bits + len_bits + 1 + n + 1;
   endfunction

endpackage

// File: rtl/serial_demux_ctrl_if.sv
// Handshake bundle between the control FSM (master) and the demux datapath (slave).
// The err line exists only when SDC_ERR_EN is defined.
interface serial_demux_ctrl_if;

   logic clkEn;
   logic serIn;
   logic co1;
   logic co2;
   logic coD;
   logic shEn;
   logic cnt1;
   logic shEnD;
   logic cnt2;
   logic ldCntD;
   logic cntD;
   logic dataValid;
   logic Done;
`ifdef SDC_ERR_EN
   logic err;
`endif

   modport master (
      input  clkEn, serIn, co1, co2, coD,
      output shEn, cnt1, shEnD, cnt2, ldCntD, cntD, dataValid, Done
`ifdef SDC_ERR_EN
      , output err
`endif
   );

   modport slave (
      output clkEn, serIn, co1, co2, coD,
      input  shEn, cnt1, shEnD, cnt2, ldCntD, cntD, dataValid, Done
`ifdef SDC_ERR_EN
      , input err
`endif
   );

endinterface

// File: rtl/serial_demux_ctrl.sv
// Control FSM sequencing the serial-to-port demux datapath one bit slot per clkEn.
// Define SDC_ERR_EN to add the stop-bit error output (err).
module serial_demux_ctrl
   import sdc_pkg::*;
#(
   parameter int PORT_BITS = PORT_BITS_DEF,
   parameter int LEN_BITS  = LEN_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_demux_ctrl_if.master  bus
);

   // Field widths live in the datapath counters; reject degenerate configurations.
   if (PORT_BITS < 1 || LEN_BITS < 1) begin : g_param_check
      $error("serial_demux_ctrl: PORT_BITS and LEN_BITS must be at least 1");
   end

   sdc_state_e   state_q;
   sdc_state_e   state_d;
   sdc_strobes_t strb;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Strobes depend only on state (and coD in DATA); clkEn gates only the advance.
   always_comb begin
      state_d = state_q;
      strb    = '0;
      case (state_q)
         ST_IDLE: begin
            if (bus.clkEn && !bus.serIn) begin
               state_d = ST_PORT;
            end
         end
         ST_PORT: begin
            strb.sh_en = 1'b1;
            strb.cnt1  = 1'b1;
            if (bus.clkEn && bus.co1) begin
               state_d = ST_LEN;
            end
         end
         ST_LEN: begin
            strb.sh_en_d = 1'b1;
            strb.cnt2    = 1'b1;
            if (bus.clkEn && bus.co2) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            strb.ld_cnt_d = 1'b1;
            if (bus.clkEn) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            // coD=1 marks the stop slot; a low bit here is never taken as a new start.
            if (bus.coD) begin
               strb.done = 1'b1;
               if (bus.clkEn) begin
                  state_d = ST_IDLE;
               end
            end else begin
               strb.cnt_d      = 1'b1;
               strb.data_valid = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.shEn      = strb.sh_en;
   assign bus.cnt1      = strb.cnt1;
   assign bus.shEnD     = strb.sh_en_d;
   assign bus.cnt2      = strb.cnt2;
   assign bus.ldCntD    = strb.ld_cnt_d;
   assign bus.cntD      = strb.cnt_d;
   assign bus.dataValid = strb.data_valid;
   assign bus.Done      = strb.done;

`ifdef SDC_ERR_EN
   // Stop bit must be high; err tracks Done exactly so it needs no state of its own.
   assign bus.err = strb.done & ~bus.serIn;
`endif

endmodule

// File: doc/serial_demux_ctrl.md
# serial_demux_ctrl

- **Role:** Moore/Mealy control FSM that sequences the serial-to-port demultiplexer datapath.
- **Frame format:** the FSM walks each serial frame in this order:
  - start bit;
  - 2-bit port number;
  - 4-bit payload length;
  - one turnaround slot;
  - N payload bits;
  - stop slot.
- **Datapath control:** it drives the shift/count/load strobes for the datapath's shift registers and counters.
- **Frame reporting:** it signals payload validity and frame completion.
- **Placement:** sits beside the datapath in the top level; all datapath handshakes go through it.

## Interface
Parameters:
- PORT_BITS, 2, width of port-number field (co1 asserts on its last bit)
- LEN_BITS, 4, width of payload-length field (co2 asserts on its last bit)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- clkEn  in  1  bit-slot enable; state advances only on cycles with clkEn=1
- serIn  in  1  serial line; idle high, start bit low
- co1  in  1  port-bit counter at final count
- co2  in  1  length-bit counter at final count
- coD  in  1  payload counter equals zero
- shEn  out  1  shift port-number register
- cnt1  out  1  advance port-bit counter
- shEnD  out  1  shift length register
- cnt2  out  1  advance length-bit counter
- ldCntD  out  1  load payload counter from length register
- cntD  out  1  decrement payload counter
- dataValid  out  1  current serIn slot is payload
- Done  out  1  frame complete (stop slot)
- err  out  1  stop-bit error pulse (present only with SDC_ERR_EN)

## Operation
- **States:**
  - IDLE
  - PORT
  - LEN
  - LOAD
  - DATA
- **Transitions:** every transition is qualified by clkEn=1.
  - IDLE: all outputs 0; serIn=0 -> PORT.
  - PORT: shEn=cnt1=1; co1=1 -> LEN, else stay.
  - LEN: shEnD=cnt2=1; co2=1 -> LOAD, else stay.
  - LOAD (turnaround slot, serIn ignored): ldCntD=1; -> DATA unconditionally.
  - DATA, coD=0: cntD=dataValid=1; stay.
  - DATA, coD=1: Done=1, cntD=0, dataValid=0; -> IDLE. This is the stop slot.
- **Output decode:**
  - Strobes are decoded from state (plus coD in DATA).
  - Strobes are not gated by clkEn; the datapath qualifies them with clkEn.
- **Length N=0:** LOAD -> DATA with coD=1 at once. Done comes in the slot after turnaround; zero payload pulses.
- **Back-to-back frames:** a start bit sampled in the stop slot is not detected. IDLE needs at least one slot before a new start is accepted.
- **serIn=0 in IDLE without clkEn:** ignored.
- **Reset mid-frame:** immediately IDLE with all outputs 0. The datapath is reset by the same system reset event.

## Timing
- Reset values: state=IDLE; shEn, cnt1, shEnD, cnt2, ldCntD, cntD, dataValid, Done, err all 0.
- Frame length in enabled slots = 1 + PORT_BITS + LEN_BITS + 1 + N + 1 (N=3 -> 12).
- Output latency: strobes change combinationally from the registered state, one clk after the advancing clkEn edge.
- Done is Mealy on coD in DATA. It stays high until the next clkEn cycle.
- No combinational path from serIn to any output except err (see below).

## Configuration
- **SDC_ERR_EN defined:**
  - Adds output err.
  - In the DATA/coD=1 slot, err = ~serIn (stop bit must be 1).
  - err is combinational with Done and has the same duration.
  - Frame still terminates -> IDLE.
- **SDC_ERR_EN undefined:**
  - No err port.
  - Stop slot value ignored.
  - No other behaviour changes.

## Structure
- **Shared package, sdc_pkg:**
  - state enum/localparams: IDLE=0, PORT=1, LEN=2, LOAD=3, DATA=4 (3-bit encoding);
  - PORT_BITS / LEN_BITS defaults.
- **Sub-module:** none required. If the stop check grows (e.g. sticky error flag), split it into sub-module sdc_stop_check.

## Test plan
- **Nominal frame:** clkEn=1 every cycle; serIn = 0, 1,0, 0,0,1,1, x, 1,0,1, 1.
  - shEn/cnt1 high 2 cycles.
  - shEnD/cnt2 high 4 cycles.
  - ldCntD high 1 cycle.
  - cntD/dataValid high 3 cycles.
  - Done high 1 cycle, then IDLE.
- **Zero length:** length field 0000.
  - No cntD/dataValid.
  - Done in the slot right after the turnaround slot.
- **Sparse clkEn:** clkEn=1 every 4th cycle, same frame as nominal.
  - Identical strobe sequence.
  - Each strobe held 4 clk cycles.
  - No state change on clkEn=0 cycles.
- **Reset mid-frame:** assert rst low during DATA (after 1 payload bit).
  - All outputs 0 asynchronously.
  - State IDLE after release.
  - Next frame completes normally.
- **Stop error (SDC_ERR_EN):** stop slot serIn=0 -> err=1 together with Done. Stop slot serIn=1 -> err=0.
- **Idle noise:** serIn=0 while clkEn=0 -> remains IDLE, all outputs 0.
